stream_fifo: RTL and testbench
==============================

// Module: stream_fifo
// PURPOSE
//   Parametrised circular-buffer FIFO for byte/word streams between the UART Rx path and downstream consumers.
//   Supports any width and depth, simultaneous read and write, first-word fall-through output, programmable
//   almost-full/almost-empty thresholds, synchronous flush and sticky error flags. Pointers wrap; no data shifting.
// PARAMETERS
//   WIDTH      8   data word width in bits (>=1)
//   DEPTH      8   number of storage words (>=2, need not be a power of 2)
//   AF_LEVEL   6   o_Almost_Full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL   2   o_Almost_Empty asserts when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//   i_Clk           in   1            system clock, all logic on rising edge
//   i_Rst_L         in   1            asynchronous, active-low reset
//   i_Clear         in   1            synchronous flush: empties FIFO, clears error flags
//   i_Wr_DV         in   1            write strobe, one word per cycle
//   i_Wr_Data       in   WIDTH        write data, sampled when i_Wr_DV=1
//   i_Rd_En         in   1            pop head word (acknowledges o_Rd_Data)
//   o_Rd_Data       out  WIDTH        head word, valid whenever o_Empty=0 (FWFT)
//   o_Full          out  1            count == DEPTH
//   o_Empty         out  1            count == 0
//   o_Almost_Full   out  1            count >= AF_LEVEL
//   o_Almost_Empty  out  1            count <= AE_LEVEL
//   o_Count         out  CW           words stored; CW = $clog2(DEPTH+1)
//   o_Overflow      out  1            sticky: write dropped
//   o_Underflow     out  1            sticky: read of empty FIFO
// BEHAVIOUR
//   Reset (i_Rst_L=0, async): wr/rd pointers=0, count=0, o_Empty=1, o_Full=0, o_Almost_Empty=1,
//     o_Almost_Full=0, o_Overflow=0, o_Underflow=0, o_Rd_Data=0 (storage not cleared; read mux gated by empty).
//   Priority per cycle: i_Clear > write/read. i_Clear=1: pointers and count to 0, flags cleared, Wr/Rd ignored.
//   Write accepted if i_Wr_DV=1 and (count<DEPTH or i_Rd_En=1 with count>0): mem[wr_ptr]<=data, wr_ptr advances.
//   Read accepted if i_Rd_En=1 and count>0: rd_ptr advances; data was already on o_Rd_Data this cycle.
//   Pointer wrap: ptr==DEPTH-1 -> 0 (explicit compare, not bit truncation).
//   Count: +1 write only, -1 read only, unchanged on both or neither. Never exceeds DEPTH or goes below 0.
//   Full + write + read: both accepted, count stays DEPTH. Empty + write + read: write accepted, read
//     rejected and o_Underflow set; o_Rd_Data shows new word next cycle (write-to-read latency 1 cycle).
//   Full + write, no read: word dropped, o_Overflow<=1. Empty + read: o_Underflow<=1, pointers unchanged.
//   All status outputs registered or derived from registered count; update one cycle after the causing edge.
//   o_Rd_Data = mem[rd_ptr] (asynchronous read of register array) when !o_Empty, else 0.
//   Reset asserted mid-stream discards all contents immediately; first write after release lands at index 0.
// STRUCTURE
//   Shared header fifo_defs.vh: CLOG2 function/macro for CW and pointer width, default WIDTH/DEPTH constants.
//   Sub-module fifo_regfile (WIDTH, DEPTH): write-port register array, async read port; top keeps
//     pointers, count, flags. No other hierarchy.
// TESTING
//   1 Reset, write 0x11..0x18 (DEPTH=8) -> o_Full=1, o_Count=8, o_Rd_Data=0x11, o_Almost_Full set at count 6.
//   2 Drain all 8 -> data 0x11..0x18 in order, o_Empty=1 after last, o_Almost_Empty set at count 2.
//   3 Full, simultaneous write 0xAA + read -> pops 0x11, count stays 8, 0xAA emerges 8th; no overflow.
//   4 Full, write 0xBB no read -> o_Overflow=1, 0xBB never read; empty, read -> o_Underflow=1, count 0.
//   5 Write/read 20 words with random gaps at DEPTH=5, WIDTH=12 -> order kept across wraps, count matches model.
//   6 4 words stored, i_Clear -> count 0, flags 0; async reset pulse mid-write -> outputs at reset values at once.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg: shared sizing helpers, defaults and operation encoding for stream_fifo.
// Revision: 1.0
`default_nettype none

package stream_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Per-cycle accepted operation, encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Ceiling log2 that never returns zero, so a vector sized by it always exists.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits++;
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo_regfile.sv
// stream_fifo_regfile: storage array with one synchronous write port and one asynchronous read port.
// Revision: 1.0
`default_nettype none

module stream_fifo_regfile
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned AW = clog2_min1(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_We,
  input  logic [AW-1:0]    i_Waddr,
  input  logic [WIDTH-1:0] i_Wdata,
  input  logic [AW-1:0]    i_Raddr,
  output logic [WIDTH-1:0] o_Rdata
);

  // Contents are deliberately not reset; the top gates the read path while empty.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge i_Clk) begin
    if (i_We) begin
      mem_q[i_Waddr] <= i_Wdata;
    end
  end

  assign o_Rdata = mem_q[i_Raddr];

endmodule

`default_nettype wire

// File: rtl/stream_fifo.sv
// stream_fifo: first-word fall-through circular FIFO with thresholds, flush and sticky error flags.
// Revision: 1.0
`default_nettype none

module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned CW = clog2_min1(DEPTH + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Clear,
  input  logic             i_Wr_DV,
  input  logic [WIDTH-1:0] i_Wr_Data,
  input  logic             i_Rd_En,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Full,
  output logic             o_Empty,
  output logic             o_Almost_Full,
  output logic             o_Almost_Empty,
  output logic [CW-1:0]    o_Count,
  output logic             o_Overflow,
  output logic             o_Underflow
);

  localparam int unsigned    PW      = clog2_min1(DEPTH);
  localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]  C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]  C_AE    = CW'(AE_LEVEL);
  localparam logic [PW-1:0]  C_LAST  = PW'(DEPTH - 1);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             w_empty, w_full, w_wr_acc, w_rd_acc;
  logic [WIDTH-1:0] w_rd_word;
  fifo_op_e         w_op;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == C_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == C_DEPTH);
  assign w_rd_acc = i_Rd_En && !w_empty && !i_Clear;
  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign w_wr_acc = i_Wr_DV && !i_Clear && (!w_full || w_rd_acc);
  assign w_op     = fifo_op_e'({w_wr_acc, w_rd_acc});

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_Clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_wr_acc) wr_ptr_d = ptr_next(wr_ptr_q);
      if (w_rd_acc) rd_ptr_d = ptr_next(rd_ptr_q);
      case (w_op)
        OP_WRITE: count_d = count_q + 1'b1;
        OP_READ:  count_d = count_q - 1'b1;
        default:  count_d = count_q;
      endcase
      if (i_Wr_DV && !w_wr_acc) overflow_d = 1'b1;
      if (i_Rd_En && w_empty)   underflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  stream_fifo_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .i_Clk   (i_Clk),
    .i_We    (w_wr_acc),
    .i_Waddr (wr_ptr_q),
    .i_Wdata (i_Wr_Data),
    .i_Raddr (rd_ptr_q),
    .o_Rdata (w_rd_word)
  );

  assign o_Rd_Data      = w_empty ? '0 : w_rd_word;
  assign o_Full         = w_full;
  assign o_Empty        = w_empty;
  assign o_Almost_Full  = (count_q >= C_AF);
  assign o_Almost_Empty = (count_q <= C_AE);
  assign o_Count        = count_q;
  assign o_Overflow     = overflow_q;
  assign o_Underflow    = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: drives a DEPTH=8 and a DEPTH=5/WIDTH=12 FIFO from one stimulus stream against a queue model.
// Revision: 1.0
`default_nettype none

module tb_stream_fifo;

  logic        clk = 1'b0;
  logic        rst_n, clr, wr, rd;
  logic [11:0] wdata;

  logic [7:0]  d8;
  logic [11:0] d5;
  logic [3:0]  c8;
  logic [2:0]  c5;
  logic [1:0]  full, empty, af, ae, ovf, unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_fifo dut8 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Clear(clr), .i_Wr_DV(wr), .i_Wr_Data(wdata[7:0]),
    .i_Rd_En(rd), .o_Rd_Data(d8), .o_Full(full[0]), .o_Empty(empty[0]),
    .o_Almost_Full(af[0]), .o_Almost_Empty(ae[0]), .o_Count(c8),
    .o_Overflow(ovf[0]), .o_Underflow(unf[0])
  );

  stream_fifo #(.WIDTH(12), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Clear(clr), .i_Wr_DV(wr), .i_Wr_Data(wdata),
    .i_Rd_En(rd), .o_Rd_Data(d5), .o_Full(full[1]), .o_Empty(empty[1]),
    .o_Almost_Full(af[1]), .o_Almost_Empty(ae[1]), .o_Count(c5),
    .o_Overflow(ovf[1]), .o_Underflow(unf[1])
  );

  function automatic int dep(input int k);  return (k == 0) ? 8 : 5; endfunction
  function automatic int afl(input int k);  return (k == 0) ? 6 : 4; endfunction
  function automatic int ael(input int k);  return (k == 0) ? 2 : 1; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: a plain queue per FIFO plus two sticky bits.
  logic [11:0] mq [2][$];
  logic [1:0]  mof = '0;
  logic [1:0]  muf = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) mq[k].delete();
      mof <= '0;
      muf <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int          n   = mq[k].size();
        automatic bit          rok = rd && (n > 0);
        automatic bit          wok = wr && ((n < dep(k)) || rok);
        automatic logic [11:0] wv  = (k == 0) ? {4'h0, wdata[7:0]} : wdata;
        if (clr) begin
          mq[k].delete();
          mof[k] <= 1'b0;
          muf[k] <= 1'b0;
        end else begin
          if (rd && n == 0) muf[k] <= 1'b1;
          if (wr && !wok)   mof[k] <= 1'b1;
          if (rok) void'(mq[k].pop_front());
          if (wok) mq[k].push_back(wv);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int          n  = mq[k].size();
      automatic logic [11:0] ed = (n > 0) ? mq[k][0] : 12'h000;
      automatic logic [11:0] ad = (k == 0) ? {4'h0, d8} : d5;
      automatic logic [3:0]  ac = (k == 0) ? c8 : {1'b0, c5};
      chk($sformatf("count[%0d]", k), 32'(ac), n);
      chk($sformatf("data[%0d]", k), 32'(ad), 32'(ed));
      chk($sformatf("full[%0d]", k), 32'(full[k]), 32'(n == dep(k)));
      chk($sformatf("empty[%0d]", k), 32'(empty[k]), 32'(n == 0));
      chk($sformatf("afull[%0d]", k), 32'(af[k]), 32'(n >= afl(k)));
      chk($sformatf("aempty[%0d]", k), 32'(ae[k]), 32'(n <= ael(k)));
      chk($sformatf("ovf[%0d]", k), 32'(ovf[k]), 32'(mof[k]));
      chk($sformatf("unf[%0d]", k), 32'(unf[k]), 32'(muf[k]));
    end
  end

  task automatic step(input logic w, input logic [11:0] d, input logic r, input logic c);
    wr = w; wdata = d; rd = r; clr = c;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) step(1'b1, 12'h011 + 12'(i), 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", 32'(c8), 0);
    chk("reset empty", 32'(empty[0]), 1);
    chk("reset aempty", 32'(ae[0]), 1);
    chk("reset data", 32'(d8), 0);
    rst_n = 1'b1;

    // Fill to full, watching the almost-full threshold
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 12'h011 + 12'(i), 1'b0, 1'b0);
      if (i == 4) chk("t1 afull@5", 32'(af[0]), 0);
      if (i == 5) chk("t1 afull@6", 32'(af[0]), 1);
    end
    chk("t1 full", 32'(full[0]), 1);
    chk("t1 count", 32'(c8), 8);
    chk("t1 head", 32'(d8), 32'h11);

    // Drain in order, watching the almost-empty threshold
    for (int i = 0; i < 8; i++) begin
      chk("t2 data", 32'(d8), 32'h11 + i);
      step(1'b0, 12'h0, 1'b1, 1'b0);
      if (i == 4) chk("t2 aempty@3", 32'(ae[0]), 0);
      if (i == 5) chk("t2 aempty@2", 32'(ae[0]), 1);
    end
    chk("t2 empty", 32'(empty[0]), 1);

    // Full with simultaneous write and read
    fill8();
    step(1'b1, 12'h0AA, 1'b1, 1'b0);
    chk("t3 count", 32'(c8), 8);
    chk("t3 head", 32'(d8), 32'h12);
    chk("t3 ovf", 32'(ovf[0]), 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3 data", 32'(d8), (i < 7) ? 32'h12 + i : 32'hAA);
      step(1'b0, 12'h0, 1'b1, 1'b0);
    end

    // Overflow then underflow, then the empty write+read corner
    fill8();
    step(1'b1, 12'h0BB, 1'b0, 1'b0);
    chk("t4 ovf", 32'(ovf[0]), 1);
    chk("t4 count", 32'(c8), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t4 data", 32'(d8), 32'h11 + i);
      step(1'b0, 12'h0, 1'b1, 1'b0);
    end
    step(1'b0, 12'h0, 1'b1, 1'b0);
    chk("t4 unf", 32'(unf[0]), 1);
    chk("t4 count0", 32'(c8), 0);
    step(1'b1, 12'h033, 1'b1, 1'b0);
    chk("t4 wr+rd empty count", 32'(c8), 1);
    chk("t4 wr+rd empty data", 32'(d8), 32'h33);
    step(1'b0, 12'h0, 1'b0, 1'b1);

    // Random traffic, both depths, rare flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end
    step(1'b0, 12'h0, 1'b0, 1'b1);

    // Flush with data, then asynchronous reset in the middle of a write
    for (int i = 0; i < 4; i++) step(1'b1, 12'h041 + 12'(i), 1'b0, 1'b0);
    chk("t6 count4", 32'(c8), 4);
    step(1'b0, 12'h0, 1'b0, 1'b1);
    chk("t6 clear count", 32'(c8), 0);
    chk("t6 clear ovf", 32'(ovf[0]), 0);
    chk("t6 clear unf", 32'(unf[0]), 0);
    wr = 1'b1; wdata = 12'h077;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6 rst count", 32'(c8), 0);
    chk("t6 rst empty", 32'(empty[0]), 1);
    chk("t6 rst data", 32'(d8), 0);
    chk("t6 rst count5", 32'(c5), 0);
    @(posedge clk); #1;
    wr = 1'b0;
    rst_n = 1'b1;
    step(1'b1, 12'h05C, 1'b0, 1'b0);
    chk("t6 post data", 32'(d8), 32'h5C);
    chk("t6 post count", 32'(c8), 1);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
